stopwatch_display: RTL and testbench
====================================

// Module: stopwatch_display
// PURPOSE
//  Stopwatch core, directly downstream of the frequency divider. Uses clk_100Hz and clk_1KHz
//  (flop outputs in the clk_50MHz domain) as rising-edge tick sources.
//  Counts MM:SS.cc in BCD under start/stop/clear buttons.
//  Drives a 6-digit multiplexed 7-segment display.
// PARAMETERS
//  MAX_MIN        59  minutes value at which the count wraps (BCD tens<=5, MAX_MIN<=59)
//  SEG_ACT_LOW    1   1: seg/dp active-low, 0: active-high
//  AN_ACT_LOW     1   1: an active-low, 0: active-high
// PORTS
//  clk_50MHz      in   1  sole clock; every flop is on its rising edge
//  rst            in   1  synchronous, active-high reset
//  clk_100Hz      in   1  divider output; rising edge = 10 ms tick
//  clk_1KHz       in   1  divider output; rising edge = digit-scan tick
//  btn_start_stop in   1  raw push button, active-high
//  btn_clear      in   1  raw push button, active-high
//  seg            out  7  segments, seg[0]=a .. seg[6]=g
//  dp             out  1  decimal point for current digit
//  an             out  6  digit enables, an[0]=rightmost (centisecond units)
//  running        out  1  1 while in RUN
//  overflow       out  1  sticky; set on wrap 59:59.99->00:00.00, cleared by clear/rst
// BEHAVIOUR
//  Ticks
//  - tick100 = clk_100Hz & ~clk_100Hz_q; tick1k likewise; _q registered every cycle.
//  - Each tick lasts exactly one clk_50MHz cycle.
//  Buttons
//  - Each button uses a 2-flop synchronizer, then is sampled only on tick100 (10 ms debounce).
//  - A press = sampled 1 with previous sample 0; it is a 1-cycle pulse in the tick100 cycle.
//  FSM, states IDLE/RUN/PAUSE; transitions evaluated in the tick100 cycle
//  - IDLE: start_stop -> RUN.
//  - RUN: start_stop -> PAUSE; clear is ignored.
//  - PAUSE: start_stop -> RUN; clear -> IDLE.
//  - IDLE, PAUSE: clear zeroes all counters and overflow; the state becomes or stays IDLE.
//  - Simultaneous presses: in IDLE/PAUSE clear wins (-> IDLE, zeroed).
//  - Simultaneous presses: in RUN start_stop acts (-> PAUSE).
//  Counting
//  - On tick100, if the current (pre-transition) state is RUN, cc increments.
//  - Six BCD digits: cs_u,cs_t (0-99), s_u,s_t (0-59), m_u,m_t (0..MAX_MIN).
//  - Carries ripple in the same cycle.
//  - At MAX_MIN:59.99 the next tick gives 00:00.00 and sets overflow; counting continues.
//  - A BCD digit never holds a value >9; tens digits never hold a value >5.
//  Scan
//  - Each tick1k advances a 3-bit index 0..5; after 5 it wraps to 0; values 6-7 are unreachable.
//  - seg/an/dp are registered: updated the cycle after tick1k, from digits current at that tick.
//  - Exactly one an bit is active, except after reset until the first tick1k.
//  - dp is lit on index 2 (s_u) and index 4 (m_u).
//  - Hex decode: 0-9 standard; non-BCD codes give blank.
//  Reset (sync)
//  - state=IDLE; digits=0; scan index=0; running=0; overflow=0.
//  - seg/dp inactive (7'h7F/1 when active-low); all an inactive.
//  - Synchronizers and edge registers are cleared to 0.
//  - Reset mid-RUN returns to IDLE at 00:00.00 on the next clock edge.
//  - A button held through reset does not register as a press until it is released and re-pressed.
// TESTING
//  1 rst=1 for 2 cycles, then idle -> seg=7'h7F, an=6'h3F, running=0, overflow=0.
//    First tick1k -> an=6'b111110, seg shows '0' (7'b1000000).
//  2 Press start_stop, 250 tick100 -> running=1, count 00:02.50.
//    Press again -> running=0; 10 more ticks -> still 00:02.50.
//  3 PAUSE at 00:02.50, press clear -> IDLE, all digits 0.
//    Press clear while RUN -> ignored, count keeps incrementing.
//  4 Preload-by-run to 59:59.98 (short divider periods), 2 ticks -> 00:00.00, overflow=1.
//    Next clear in PAUSE -> overflow=0.
//  5 Both buttons pressed in the same tick100: in PAUSE -> IDLE zeroed; in RUN -> PAUSE, count kept.
//  6 Glitch btn_start_stop high for <1 tick100 period between ticks -> no state change.
//    Assert rst while RUN -> next cycle IDLE, 00:00.00.

Source files
------------

// File: rtl/stopwatch_display.sv
// Stopwatch core: debounced start/stop/clear buttons, BCD MM:SS.cc counter and
// a registered 6-digit multiplexed 7-segment driver, all in the clk_50MHz domain.
//
// state | meaning
// IDLE  | stopped at 00:00.00, waiting for start
// RUN   | counting one centisecond per 10 ms tick
// PAUSE | stopped with count held; start resumes, clear returns to IDLE
module stopwatch_display #(
    parameter int MAX_MIN     = 59,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       clk_100Hz,
    input  logic       clk_1KHz,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       running,
    output logic       overflow
);

    localparam logic [3:0] MAX_MT  = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_MU  = 4'(MAX_MIN % 10);
    localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACT_LOW;
    localparam logic [5:0] AN_OFF  = AN_ACT_LOW ? 6'h3F : 6'h00;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state_q, state_d;
    logic       c100_q, c1k_q;
    logic [1:0] ss_sync_q, clr_sync_q;
    logic       ss_samp_q, clr_samp_q;
    logic [3:0] cs_u_q, cs_t_q, s_u_q, s_t_q, m_u_q, m_t_q;
    logic [3:0] cs_u_d, cs_t_d, s_u_d, s_t_d, m_u_d, m_t_d;
    logic       ovf_q, ovf_d;
    logic [2:0] idx_q;
    logic [6:0] seg_q;
    logic       dp_q;
    logic [5:0] an_q;

    logic       tick100, tick1k;
    logic       press_ss, press_clr;
    logic       clear_cnt;
    logic [3:0] cur_digit;
    logic       dp_on;

    assign tick100   = clk_100Hz & ~c100_q;
    assign tick1k    = clk_1KHz & ~c1k_q;
    assign press_ss  = tick100 & ss_sync_q[1] & ~ss_samp_q;
    assign press_clr = tick100 & clr_sync_q[1] & ~clr_samp_q;

    always_comb begin
        state_d   = state_q;
        clear_cnt = 1'b0;
        if (tick100) begin
            case (state_q)
                IDLE, PAUSE: begin
                    if (press_clr) begin
                        state_d   = IDLE;
                        clear_cnt = 1'b1;
                    end else if (press_ss) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (press_ss) begin
                        state_d = PAUSE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Carry chain ripples through all six digits in a single cycle.
    always_comb begin
        cs_u_d = cs_u_q;
        cs_t_d = cs_t_q;
        s_u_d  = s_u_q;
        s_t_d  = s_t_q;
        m_u_d  = m_u_q;
        m_t_d  = m_t_q;
        ovf_d  = ovf_q;
        if (clear_cnt) begin
            cs_u_d = 4'd0;
            cs_t_d = 4'd0;
            s_u_d  = 4'd0;
            s_t_d  = 4'd0;
            m_u_d  = 4'd0;
            m_t_d  = 4'd0;
            ovf_d  = 1'b0;
        end else if (tick100 && state_q == RUN) begin
            if (cs_u_q < 4'd9) begin
                cs_u_d = cs_u_q + 4'd1;
            end else begin
                cs_u_d = 4'd0;
                if (cs_t_q < 4'd9) begin
                    cs_t_d = cs_t_q + 4'd1;
                end else begin
                    cs_t_d = 4'd0;
                    if (s_u_q < 4'd9) begin
                        s_u_d = s_u_q + 4'd1;
                    end else begin
                        s_u_d = 4'd0;
                        if (s_t_q < 4'd5) begin
                            s_t_d = s_t_q + 4'd1;
                        end else begin
                            s_t_d = 4'd0;
                            if (m_t_q == MAX_MT && m_u_q == MAX_MU) begin
                                m_t_d = 4'd0;
                                m_u_d = 4'd0;
                                ovf_d = 1'b1;
                            end else if (m_u_q < 4'd9) begin
                                m_u_d = m_u_q + 4'd1;
                            end else begin
                                m_u_d = 4'd0;
                                m_t_d = m_t_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Debounce samples reset to 1 so a button held through reset needs a release first.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_q    <= IDLE;
            c100_q     <= 1'b0;
            c1k_q      <= 1'b0;
            ss_sync_q  <= 2'b00;
            clr_sync_q <= 2'b00;
            ss_samp_q  <= 1'b1;
            clr_samp_q <= 1'b1;
            cs_u_q     <= 4'd0;
            cs_t_q     <= 4'd0;
            s_u_q      <= 4'd0;
            s_t_q      <= 4'd0;
            m_u_q      <= 4'd0;
            m_t_q      <= 4'd0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            c100_q     <= clk_100Hz;
            c1k_q      <= clk_1KHz;
            ss_sync_q  <= {ss_sync_q[0], btn_start_stop};
            clr_sync_q <= {clr_sync_q[0], btn_clear};
            if (tick100) begin
                ss_samp_q  <= ss_sync_q[1];
                clr_samp_q <= clr_sync_q[1];
            end
            cs_u_q <= cs_u_d;
            cs_t_q <= cs_t_d;
            s_u_q  <= s_u_d;
            s_t_q  <= s_t_d;
            m_u_q  <= m_u_d;
            m_t_q  <= m_t_d;
            ovf_q  <= ovf_d;
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h00;
        endcase
    endfunction

    always_comb begin
        case (idx_q)
            3'd0:    cur_digit = cs_u_q;
            3'd1:    cur_digit = cs_t_q;
            3'd2:    cur_digit = s_u_q;
            3'd3:    cur_digit = s_t_q;
            3'd4:    cur_digit = m_u_q;
            3'd5:    cur_digit = m_t_q;
            default: cur_digit = 4'hF;
        endcase
    end

    // Decimal points separate seconds from centiseconds and minutes from seconds.
    assign dp_on = (idx_q == 3'd2) || (idx_q == 3'd4);

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            idx_q <= 3'd0;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
            an_q  <= AN_OFF;
        end else if (tick1k) begin
            idx_q <= (idx_q >= 3'd5) ? 3'd0 : idx_q + 3'd1;
            seg_q <= SEG_ACT_LOW ? ~seg_decode(cur_digit) : seg_decode(cur_digit);
            dp_q  <= SEG_ACT_LOW ? ~dp_on : dp_on;
            an_q  <= AN_ACT_LOW ? ~(6'b000001 << idx_q) : (6'b000001 << idx_q);
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign running  = (state_q == RUN);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Randomized bench for stopwatch_display; a centisecond-count model with the
// start/stop/clear rules predicts status outputs and every scanned digit.
module tb_stopwatch_display;

    localparam int MAX_MIN  = 1;
    localparam int WRAP     = (MAX_MIN + 1) * 6000;
    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       c100;
    logic       c1k;
    logic       bss;
    logic       bcl;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       running;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;

    int m_state;
    int m_cnt;
    bit m_ovf;
    int m_si;
    bit m_prev_ss;
    bit m_prev_cl;

    stopwatch_display #(
        .MAX_MIN    (MAX_MIN),
        .SEG_ACT_LOW(1'b1),
        .AN_ACT_LOW (1'b1)
    ) dut (
        .clk_50MHz     (clk),
        .rst           (rst),
        .clk_100Hz     (c100),
        .clk_1KHz      (c1k),
        .btn_start_stop(bss),
        .btn_clear     (bcl),
        .seg           (seg),
        .dp            (dp),
        .an            (an),
        .running       (running),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'h3F;
            1:       return 7'h06;
            2:       return 7'h5B;
            3:       return 7'h4F;
            4:       return 7'h66;
            5:       return 7'h6D;
            6:       return 7'h7D;
            7:       return 7'h07;
            8:       return 7'h7F;
            9:       return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int model_digit(input int i);
        int cs;
        int sec;
        int mins;
        cs   = m_cnt % 100;
        sec  = (m_cnt / 100) % 60;
        mins = m_cnt / 6000;
        case (i)
            0:       return cs % 10;
            1:       return cs / 10;
            2:       return sec % 10;
            3:       return sec / 10;
            4:       return mins % 10;
            default: return mins / 10;
        endcase
    endfunction

    task automatic model_reset();
        m_state   = ST_IDLE;
        m_cnt     = 0;
        m_ovf     = 1'b0;
        m_si      = 0;
        m_prev_ss = 1'b1;
        m_prev_cl = 1'b1;
    endtask

    task automatic model_tick();
        bit p_ss;
        bit p_cl;
        p_ss      = bss && !m_prev_ss;
        p_cl      = bcl && !m_prev_cl;
        m_prev_ss = bss;
        m_prev_cl = bcl;
        if (m_state == ST_RUN) begin
            m_cnt++;
            if (m_cnt == WRAP) begin
                m_cnt = 0;
                m_ovf = 1'b1;
            end
            if (p_ss) m_state = ST_PAUSE;
        end else if (p_cl) begin
            m_state = ST_IDLE;
            m_cnt   = 0;
            m_ovf   = 1'b0;
        end else if (p_ss) begin
            m_state = ST_RUN;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        model_reset();
        cyc(2);
    endtask

    task automatic set_btns(input logic ss, input logic cl);
        bss = ss;
        bcl = cl;
        cyc(2);
    endtask

    task automatic tick100();
        c100 = 1'b1;
        cyc(1);
        c100 = 1'b0;
        cyc(1);
        model_tick();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick100();
    endtask

    task automatic scan_check(input string tag);
        logic [6:0] exp_seg;
        logic [5:0] exp_an;
        logic       exp_dp;
        exp_seg = ~seg_of(model_digit(m_si));
        exp_an  = ~(6'b000001 << m_si);
        exp_dp  = !(m_si == 2 || m_si == 4);
        c1k = 1'b1;
        cyc(1);
        c1k = 1'b0;
        n_cmp++;
        if (seg !== exp_seg) begin
            n_bad++;
            $display("FAIL %s seg idx%0d: got %b want %b", tag, m_si, seg, exp_seg);
        end
        n_cmp++;
        if (an !== exp_an) begin
            n_bad++;
            $display("FAIL %s an idx%0d: got %b want %b", tag, m_si, an, exp_an);
        end
        n_cmp++;
        if (dp !== exp_dp) begin
            n_bad++;
            $display("FAIL %s dp idx%0d: got %b want %b", tag, m_si, dp, exp_dp);
        end
        cyc(1);
        m_si = (m_si == 5) ? 0 : m_si + 1;
    endtask

    task automatic check_display(input string tag);
        repeat (6) scan_check(tag);
    endtask

    task automatic check_status(input string tag);
        n_cmp++;
        if (running !== (m_state == ST_RUN)) begin
            n_bad++;
            $display("FAIL %s running: got %b want %b", tag, running, (m_state == ST_RUN));
        end
        n_cmp++;
        if (overflow !== m_ovf) begin
            n_bad++;
            $display("FAIL %s overflow: got %b want %b", tag, overflow, m_ovf);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL reset seg: got %h want 7f", seg);
        end
        n_cmp++;
        if (an !== 6'h3F) begin
            n_bad++;
            $display("FAIL reset an: got %h want 3f", an);
        end
        n_cmp++;
        if (dp !== 1'b1) begin
            n_bad++;
            $display("FAIL reset dp: got %b want 1", dp);
        end
        check_status("reset");
        scan_check("first_scan");
        n_cmp++;
        if (an !== 6'b111110 || seg !== 7'b1000000) begin
            n_bad++;
            $display("FAIL first_scan literal: got an=%b seg=%b want 111110/1000000", an, seg);
        end
        check_display("reset_digits");
    endtask

    task automatic test_run_pause();
        set_btns(1'b1, 1'b0);
        tick100();
        set_btns(1'b0, 1'b0);
        ticks(250);
        check_status("run_250");
        check_display("run_250");
        set_btns(1'b1, 1'b0);
        tick100();
        set_btns(1'b0, 1'b0);
        ticks(10);
        check_status("paused");
        check_display("paused");
    endtask

    task automatic test_clear();
        set_btns(1'b0, 1'b1);
        tick100();
        set_btns(1'b0, 1'b0);
        tick100();
        check_status("clear_pause");
        check_display("clear_pause");
        set_btns(1'b1, 1'b0);
        tick100();
        set_btns(1'b0, 1'b0);
        ticks(37);
        set_btns(1'b0, 1'b1);
        tick100();
        set_btns(1'b0, 1'b0);
        ticks(5);
        check_status("clear_in_run");
        check_display("clear_in_run");
    endtask

    task automatic test_wrap();
        int guard;
        do_reset();
        set_btns(1'b1, 1'b0);
        tick100();
        set_btns(1'b0, 1'b0);
        guard = 0;
        while (m_cnt != WRAP - 2 && guard < WRAP) begin
            tick100();
            guard++;
        end
        check_status("pre_wrap");
        check_display("pre_wrap");
        ticks(2);
        check_status("wrap");
        check_display("wrap");
        ticks(3);
        check_status("post_wrap");
        set_btns(1'b1, 1'b0);
        tick100();
        set_btns(1'b0, 1'b0);
        tick100();
        set_btns(1'b0, 1'b1);
        tick100();
        set_btns(1'b0, 1'b0);
        tick100();
        check_status("ovf_clear");
        check_display("ovf_clear");
    endtask

    task automatic test_simultaneous();
        set_btns(1'b1, 1'b0);
        tick100();
        set_btns(1'b0, 1'b0);
        ticks(30);
        set_btns(1'b1, 1'b1);
        tick100();
        set_btns(1'b0, 1'b0);
        tick100();
        check_status("both_in_run");
        check_display("both_in_run");
        set_btns(1'b1, 1'b1);
        tick100();
        set_btns(1'b0, 1'b0);
        tick100();
        check_status("both_in_pause");
        check_display("both_in_pause");
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 4; i++) begin
            bss = 1'b1;
            cyc(1 + i);
            bss = 1'b0;
            cyc(2);
            tick100();
        end
        check_status("glitch");
        check_display("glitch");
    endtask

    task automatic test_held_reset();
        set_btns(1'b1, 1'b0);
        do_reset();
        ticks(3);
        check_status("held_reset");
        set_btns(1'b0, 1'b0);
        tick100();
        set_btns(1'b1, 1'b0);
        tick100();
        set_btns(1'b0, 1'b0);
        check_status("repress");
    endtask

    task automatic test_reset_mid_run();
        ticks(50);
        rst = 1'b1;
        cyc(1);
        n_cmp++;
        if (running !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun_reset running: got %b want 0", running);
        end
        n_cmp++;
        if (an !== 6'h3F || seg !== 7'h7F) begin
            n_bad++;
            $display("FAIL midrun_reset outputs: got an=%h seg=%h want 3f/7f", an, seg);
        end
        cyc(1);
        rst = 1'b0;
        model_reset();
        cyc(2);
        check_status("midrun_reset");
        check_display("midrun_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            set_btns(1'((int'($urandom_range(0, 3)) == 0)), 1'((int'($urandom_range(0, 4)) == 0)));
            if (!bss && int'($urandom_range(0, 3)) == 0) begin
                bss = 1'b1;
                cyc(int'($urandom_range(1, 3)));
                bss = 1'b0;
                cyc(2);
            end
            ticks(int'($urandom_range(1, 40)));
            check_status("random");
            if (int'($urandom_range(0, 1)) == 1) scan_check("random_scan");
            if (it % 10 == 9) check_display("random_digits");
        end
    endtask

    initial begin
        rst  = 1'b1;
        c100 = 1'b0;
        c1k  = 1'b0;
        bss  = 1'b0;
        bcl  = 1'b0;
        model_reset();
        test_reset();
        test_run_pause();
        test_clear();
        test_wrap();
        test_simultaneous();
        test_glitch();
        test_held_reset();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
